instr_execute_unit: RTL and testbench

//   Execute stage directly downstream of the 3-nibble instruction fetcher.
//   - Accepts one 12-bit instruction {nib1,nib2,nib3} per valid/ready handshake.
//   - Executes it against a nibble register file and Z/C flags.
//   - Returns a PC redirect (pc_load/pc_target) to the fetcher on taken jumps.
//   - Drives a registered 4-bit output port.

---
 rtl/instr_execute_unit.sv | 144 ++++++++++++++
 tb/tb_instr_execute_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/instr_execute_unit.sv
// rtl/instr_execute_unit.sv - nibble execute stage: register file, Z/C flags, PC redirect, output port
// Optional multiplier for opcode D is enabled by defining EXEC_MUL_EN.
module instr_execute_unit #(
  parameter int NUM_REGS = 16,
  parameter int PC_W     = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [11:0]     instr,
  output logic            instr_ready,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_target,
  input  logic [3:0]      in_data,
  output logic [3:0]      out_data,
  output logic            out_strobe,
  output logic            halted
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, HALT} state_t;

  state_t      state, state_n;
  logic [11:0] instr_q;
  logic [3:0]  regs [NUM_REGS];
  logic        z, c;

  logic [3:0]    op, fa, fb;
  logic [AW-1:0] ra, rb;
  logic [3:0]    va, vb;

  assign op = instr_q[11:8];
  assign fa = instr_q[7:4];
  assign fb = instr_q[3:0];
  assign ra = instr_q[4 +: AW];
  assign rb = instr_q[0 +: AW];
  assign va = regs[ra];
  assign vb = regs[rb];

  logic       wr_en, z_en, c_en, c_new, jump, taken, out_en;
  logic [3:0] res;
  logic [4:0] sum;
`ifdef EXEC_MUL_EN
  logic [7:0] prod;
`endif

  // Operands are read combinationally, so A==B sees the pre-op value on both sides.
  always_comb begin
    wr_en  = 1'b0;
    z_en   = 1'b0;
    c_en   = 1'b0;
    c_new  = c;
    jump   = 1'b0;
    taken  = 1'b0;
    out_en = 1'b0;
    res    = 4'h0;
    sum    = 5'h0;
`ifdef EXEC_MUL_EN
    prod   = 8'h0;
`endif
    case (op)
      4'h1: begin wr_en = 1'b1; res = fb; end
      4'h2: begin
        sum   = {1'b0, va} + {1'b0, vb};
        res   = sum[3:0];
        c_new = sum[4];
        wr_en = 1'b1; z_en = 1'b1; c_en = 1'b1;
      end
      4'h3: begin
        res   = va - vb;
        c_new = (va >= vb);
        wr_en = 1'b1; z_en = 1'b1; c_en = 1'b1;
      end
      4'h4: begin res = va & vb; wr_en = 1'b1; z_en = 1'b1; end
      4'h5: begin res = va | vb; wr_en = 1'b1; z_en = 1'b1; end
      4'h6: begin res = va ^ vb; wr_en = 1'b1; z_en = 1'b1; end
      4'h7: begin res = vb; wr_en = 1'b1; end
      4'h8: begin jump = 1'b1; taken = 1'b1; end
      4'h9: begin jump = 1'b1; taken = z; end
      4'hA: begin jump = 1'b1; taken = c; end
      4'hB: out_en = 1'b1;
      4'hC: begin res = in_data; wr_en = 1'b1; z_en = 1'b1; end
`ifdef EXEC_MUL_EN
      4'hD: begin
        prod  = {4'h0, va} * {4'h0, vb};
        res   = prod[3:0];
        c_new = |prod[7:4];
        wr_en = 1'b1; z_en = 1'b1; c_en = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_n     = state;
    instr_ready = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_n = EXEC;
      end
      EXEC:    state_n = (op == 4'hF) ? HALT : IDLE;
      HALT:    state_n = HALT;
      default: state_n = IDLE;
    endcase
  end

  assign halted = (state == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      instr_q    <= 12'h000;
      z          <= 1'b0;
      c          <= 1'b0;
      out_data   <= 4'h0;
      out_strobe <= 1'b0;
      pc_load    <= 1'b0;
      pc_target  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 4'h0;
    end else begin
      state      <= state_n;
      pc_load    <= 1'b0;
      out_strobe <= 1'b0;
      if (state == IDLE && instr_valid) instr_q <= instr;
      if (state == EXEC) begin
        if (wr_en) regs[ra] <= res;
        if (z_en)  z <= (res == 4'h0);
        if (c_en)  c <= c_new;
        if (jump) begin
          pc_target <= PC_W'({fa, fb, 2'b00});
          pc_load   <= taken;
        end
        if (out_en) begin
          out_data   <= va;
          out_strobe <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_execute_unit.sv
// tb/tb_instr_execute_unit.sv - randomized scoreboard bench for instr_execute_unit
// Define EXEC_MUL_EN for both bench and design to cover the multiplier build.
module tb_instr_execute_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [11:0] instr;
  logic        instr_ready;
  logic        pc_load;
  logic [9:0]  pc_target;
  logic [3:0]  in_data;
  logic [3:0]  out_data;
  logic        out_strobe;
  logic        halted;

  instr_execute_unit #(.NUM_REGS(16), .PC_W(10)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .pc_load(pc_load), .pc_target(pc_target),
    .in_data(in_data), .out_data(out_data), .out_strobe(out_strobe), .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_out[$];
  int exp_pc[$];
  int mr[16];
  bit mz, mc;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference semantics: plain integer arithmetic on a register array.
  task automatic model(input logic [11:0] i, input int ind);
    int op, a, b, r;
    op = int'(i[11:8]); a = int'(i[7:4]); b = int'(i[3:0]);
    case (op)
      1: mr[a] = b;
      2: begin r = mr[a] + mr[b]; mc = (r > 15); mr[a] = r % 16; mz = (mr[a] == 0); end
      3: begin mc = (mr[a] >= mr[b]); mr[a] = (mr[a] - mr[b] + 16) % 16; mz = (mr[a] == 0); end
      4: begin mr[a] = mr[a] & mr[b]; mz = (mr[a] == 0); end
      5: begin mr[a] = mr[a] | mr[b]; mz = (mr[a] == 0); end
      6: begin mr[a] = mr[a] ^ mr[b]; mz = (mr[a] == 0); end
      7: mr[a] = mr[b];
      8: exp_pc.push_back((a * 16 + b) * 4);
      9: if (mz) exp_pc.push_back((a * 16 + b) * 4);
      10: if (mc) exp_pc.push_back((a * 16 + b) * 4);
      11: exp_out.push_back(mr[a]);
      12: begin mr[a] = ind; mz = (mr[a] == 0); end
`ifdef EXEC_MUL_EN
      13: begin r = mr[a] * mr[b]; mc = (r > 15); mr[a] = r % 16; mz = (mr[a] == 0); end
`endif
      default: ;
    endcase
  endtask

  // Leaves instr_valid high with garbage during EXEC, as a fetcher holding its next word would.
  task automatic issue(input logic [11:0] i, input logic [3:0] d);
    int n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      check("issue_timeout", int'(instr_ready), 1);
      instr_valid = 1'b0;
      return;
    end
    in_data     = d;
    instr       = i;
    instr_valid = 1'b1;
    model(i, int'(d));
    @(negedge clk);
    instr = 12'($urandom);
  endtask

  task automatic gap(input int n);
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) mr[k] = 0;
    mz = 1'b0;
    mc = 1'b0;
    exp_out.delete();
    exp_pc.delete();
  endtask

  always @(negedge clk) begin
    int e;
    if (!rst) begin
      if (out_strobe) begin
        if (exp_out.size() == 0) begin
          check("unexpected_out_strobe", 1, 0);
        end else begin
          e = exp_out.pop_front();
          check("out_data", int'(out_data), e);
        end
      end
      if (pc_load) begin
        if (exp_pc.size() == 0) begin
          check("unexpected_pc_load", 1, 0);
        end else begin
          e = exp_pc.pop_front();
          check("pc_target", int'(pc_target), e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = 12'h000; in_data = 4'h0;

    do_reset();
    check("rst_ready", int'(instr_ready), 1);
    check("rst_out_data", int'(out_data), 0);
    check("rst_halted", int'(halted), 0);
    check("rst_pc_load", int'(pc_load), 0);
    check("rst_out_strobe", int'(out_strobe), 0);
    check("rst_pc_target", int'(pc_target), 0);

    issue(12'h119, 4'h0); issue(12'h128, 4'h0); issue(12'h212, 4'h0); issue(12'hB10, 4'h0);
    gap(1);
    check("add_wrap_out", int'(out_data), 1);
    check("add_wrap_strobe", int'(out_strobe), 1);
    gap(1);
    check("strobe_one_cycle", int'(out_strobe), 0);
    issue(12'hA01, 4'h0); issue(12'h902, 4'h0);

    issue(12'h135, 4'h0); issue(12'h333, 4'h0); issue(12'h927, 4'h0);
    gap(1);
    check("jz_target", int'(pc_target), 10'h09C);
    check("jz_pc_load", int'(pc_load), 1);
    gap(1);
    check("pc_load_one_cycle", int'(pc_load), 0);
    issue(12'hA00, 4'h0);

    issue(12'h181, 4'h0); issue(12'h192, 4'h0); issue(12'h389, 4'h0); issue(12'hA11, 4'h0);
    issue(12'h142, 4'h0); issue(12'h344, 4'h0); issue(12'hAAB, 4'h0); issue(12'h8FF, 4'h0);
    gap(1);
    check("jmp_ff_target", int'(pc_target), 10'h3FC);

    issue(12'h167, 4'h0); issue(12'h173, 4'h0); issue(12'hD67, 4'h0); issue(12'hB60, 4'h0);
    gap(1);
`ifdef EXEC_MUL_EN
    check("mul_result", int'(out_data), 5);
`else
    check("mul_disabled", int'(out_data), 7);
`endif

    issue(12'h1A5, 4'h0);
    do_reset();
    issue(12'hBA0, 4'h0);
    gap(1);
    check("inflight_discard", int'(out_data), 0);

    for (int n = 0; n < 400; n++) begin
      issue({4'($urandom_range(0, 14)), 8'($urandom)}, 4'($urandom));
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
    end

    issue(12'hC50, 4'h0); issue(12'h904, 4'h0);
    issue(12'hF00, 4'h0);
    gap(1);
    check("halted", int'(halted), 1);
    check("halt_ready", int'(instr_ready), 0);
    instr = 12'hB10;
    instr_valid = 1'b1;
    repeat (6) @(negedge clk);
    check("halt_sticky", int'(halted), 1);
    do_reset();
    check("post_halt_ready", int'(instr_ready), 1);
    check("post_halt_halted", int'(halted), 0);

    check("out_queue_empty", exp_out.size(), 0);
    check("pc_queue_empty", exp_pc.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
